// File: rtl/regfile_sb_pkg.sv
// Shared constants and the flag-register transform for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ZERO_IDX_DEF = 0;
    localparam int PC_IDX_DEF   = 15;
    localparam int T_IDX_DEF    = 14;
    localparam int MAX_DATA_W   = 64;

    // Flag register stores only "value was zero"; callers cast to their own width.
    function automatic logic [MAX_DATA_W-1:0] t_xform(input logic [MAX_DATA_W-1:0] v);
        return {{(MAX_DATA_W-1){1'b0}}, (v == '0)};
    endfunction

endpackage

// File: rtl/regfile_rd_mux.sv
// One combinational read port: zero / PC / array select and busy lookup.
// With REGFILE_BYPASS_EN defined, the in-flight write is forwarded to the port.
module regfile_rd_mux
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = 4,
    parameter int ZERO_IDX = ZERO_IDX_DEF,
    parameter int PC_IDX   = PC_IDX_DEF,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
    input  logic [DEPTH-1:0]              busy,
    input  logic [DATA_W-1:0]             pc_addr,
`ifdef REGFILE_BYPASS_EN
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_value,
    input  logic                          set_busy,
    input  logic [ADDR_W-1:0]             busy_reg,
`endif
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_busy
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);

    always_comb begin
        rd_data = regs[rd_addr];
        rd_busy = busy[rd_addr];
        if (rd_addr == ZERO_A) begin
            rd_data = '0;
        end else if (rd_addr == PC_A) begin
            rd_data = pc_addr;
        end
`ifdef REGFILE_BYPASS_EN
        // A same-cycle SetBusy to this index means a newer op is pending, so keep busy.
        if (wr_en && (wr_addr == rd_addr) && (rd_addr != ZERO_A) && (rd_addr != PC_A)) begin
            rd_data = wr_value;
            if (!(set_busy && (busy_reg == rd_addr))) begin
                rd_busy = 1'b0;
            end
        end
`endif
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with zero/PC/T special indices and a per-register busy scoreboard.
// Optional write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_IDX = ZERO_IDX_DEF,
    parameter int PC_IDX   = PC_IDX_DEF,
    parameter int T_IDX    = T_IDX_DEF,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
    input  logic [NUM_RD-1:0]          RdEn,
    output logic [NUM_RD*DATA_W-1:0]   RdData,
    output logic [NUM_RD-1:0]          RdBusy,
    output logic                       Stall,
    input  logic [DATA_W-1:0]          PcAddr0,
    input  logic                       RegWre,
    input  logic [ADDR_W-1:0]          WriteReg,
    input  logic [DATA_W-1:0]          WriteData,
    input  logic                       SetBusy,
    input  logic [ADDR_W-1:0]          BusyReg,
    input  logic [ADDR_W-1:0]          PeekSel,
    output logic [DATA_W-1:0]          RegPeek,
    output logic [DEPTH-1:0]           BusyVec
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] T_A    = ADDR_W'(T_IDX);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [DATA_W-1:0]            peek_q, peek_d;
    logic [DATA_W-1:0]            wr_value;
    logic                         wr_legal;

    assign wr_legal = RegWre && (WriteReg != ZERO_A) && (WriteReg != PC_A);
    assign wr_value = (WriteReg == T_A) ? DATA_W'(t_xform(MAX_DATA_W'(WriteData))) : WriteData;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_legal) begin
            regs_d[WriteReg] = wr_value;
        end
        if (RegWre) begin
            busy_d[WriteReg] = 1'b0;
        end
        // Set after clear: a new pending op supersedes the one just retired.
        if (SetBusy && (BusyReg != ZERO_A) && (BusyReg != PC_A)) begin
            busy_d[BusyReg] = 1'b1;
        end
        if (PeekSel == PC_A) begin
            peek_d = PcAddr0;
        end else if (PeekSel == ZERO_A) begin
            peek_d = '0;
        end else begin
            peek_d = regs_d[PeekSel];
        end
    end

    always_ff @(negedge Clk or negedge Rst) begin
        if (!Rst) begin
            regs_q <= '0;
            busy_q <= '0;
            peek_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            peek_q <= peek_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_IDX (ZERO_IDX),
            .PC_IDX   (PC_IDX)
        ) u_rd_mux (
            .rd_addr  (RdAddr[k*ADDR_W +: ADDR_W]),
            .regs     (regs_q),
            .busy     (busy_q),
            .pc_addr  (PcAddr0),
`ifdef REGFILE_BYPASS_EN
            .wr_en    (RegWre),
            .wr_addr  (WriteReg),
            .wr_value (wr_value),
            .set_busy (SetBusy),
            .busy_reg (BusyReg),
`endif
            .rd_data  (RdData[k*DATA_W +: DATA_W]),
            .rd_busy  (RdBusy[k])
        );
    end

    assign Stall   = |(RdEn & RdBusy);
    assign RegPeek = peek_q;
    assign BusyVec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default 16-bit/2-port instance plus a 32-bit/3-port one.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b1;
    logic        Rst;
    logic [7:0]  RdAddr;
    logic [1:0]  RdEn;
    logic [31:0] RdData;
    logic [1:0]  RdBusy;
    logic        Stall;
    logic [15:0] PcAddr0;
    logic        RegWre;
    logic [3:0]  WriteReg;
    logic [15:0] WriteData;
    logic        SetBusy;
    logic [3:0]  BusyReg;
    logic [3:0]  PeekSel;
    logic [15:0] RegPeek;
    logic [15:0] BusyVec;

    logic [14:0] w_rd_addr;
    logic [2:0]  w_rd_en;
    logic [95:0] w_rd_data;
    logic [2:0]  w_rd_busy;
    logic        w_stall;
    logic [31:0] w_pc;
    logic        w_wre;
    logic [4:0]  w_wreg;
    logic [31:0] w_wdata;
    logic        w_set;
    logic [4:0]  w_breg;
    logic [4:0]  w_peek_sel;
    logic [31:0] w_peek;
    logic [31:0] w_busy_vec;

    always #5 Clk = ~Clk;

    regfile_sb dut (
        .Clk(Clk), .Rst(Rst), .RdAddr(RdAddr), .RdEn(RdEn), .RdData(RdData),
        .RdBusy(RdBusy), .Stall(Stall), .PcAddr0(PcAddr0), .RegWre(RegWre),
        .WriteReg(WriteReg), .WriteData(WriteData), .SetBusy(SetBusy),
        .BusyReg(BusyReg), .PeekSel(PeekSel), .RegPeek(RegPeek), .BusyVec(BusyVec)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) dut_w (
        .Clk(Clk), .Rst(Rst), .RdAddr(w_rd_addr), .RdEn(w_rd_en), .RdData(w_rd_data),
        .RdBusy(w_rd_busy), .Stall(w_stall), .PcAddr0(w_pc), .RegWre(w_wre),
        .WriteReg(w_wreg), .WriteData(w_wdata), .SetBusy(w_set),
        .BusyReg(w_breg), .PeekSel(w_peek_sel), .RegPeek(w_peek), .BusyVec(w_busy_vec)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return {16'h0, RdData[15:0]};
            1:       return {16'h0, RdData[31:16]};
            2:       return {30'h0, RdBusy};
            3:       return {31'h0, Stall};
            4:       return {16'h0, RegPeek};
            5:       return {16'h0, BusyVec};
            6:       return w_rd_data[31:0];
            7:       return w_rd_data[63:32];
            8:       return w_rd_data[95:64];
            9:       return w_busy_vec;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic want(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain;
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic step;
        @(negedge Clk);
        #1;
    endtask

    task automatic idle;
        RegWre  = 1'b0;
        SetBusy = 1'b0;
        w_wre   = 1'b0;
        w_set   = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        RegWre    = 1'b1;
        WriteReg  = a;
        WriteData = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time budget");
        $fatal(1);
    end

    initial begin
        Rst = 1'b0;
        RdAddr = {4'd15, 4'd3}; RdEn = 2'b00; PcAddr0 = 16'h0;
        WriteReg = 4'd0; WriteData = 16'h0; BusyReg = 4'd0; PeekSel = 4'd0;
        w_rd_addr = '0; w_rd_en = '0; w_pc = '0; w_wreg = '0; w_wdata = '0;
        w_breg = '0; w_peek_sel = '0;
        idle();
        #2;
        want("rst_rd_r3", 0, 32'h0);
        want("rst_busyvec", 5, 32'h0);
        want("rst_peek", 4, 32'h0);
        drain();
        @(posedge Clk);
        Rst = 1'b1;
        step();

        // zero register ignores writes
        wr(4'd0, 16'hFFFF);
        step(); idle();
        RdAddr[3:0] = 4'd0;
        #1; want("zero_rd", 0, 32'h0); drain();

        // PC alias
        PcAddr0 = 16'h0040;
        RdAddr[7:4] = 4'd15;
        #1; want("pc_rd", 1, 32'h0040); drain();

        // T register compare-to-zero, with peek of same index on the same edge
        wr(4'd14, 16'h0000); PeekSel = 4'd14;
        want("t_zero_rd", 0, 32'h1);
        want("t_zero_peek", 4, 32'h1);
        step(); idle();
        RdAddr[3:0] = 4'd14;
        #1; drain();
        wr(4'd14, 16'h0007);
        want("t_nonzero_rd", 0, 32'h0);
        step(); idle(); drain();

        // scoreboard set and stall
        SetBusy = 1'b1; BusyReg = 4'd6;
        step(); idle();
        RdAddr[3:0] = 4'd6; RdEn = 2'b01;
        want("busy6_rdbusy", 2, 32'h1);
        want("busy6_stall", 3, 32'h1);
        want("busy6_vec", 5, 32'h0040);
        #1; drain();
        RdEn = 2'b00;
        #1; want("stall_rden0", 3, 32'h0); drain();
        RdEn = 2'b01;

        // ignored and idempotent sets
        SetBusy = 1'b1; BusyReg = 4'd0;  step();
        BusyReg = 4'd15; step();
        BusyReg = 4'd6;  step(); idle();
        want("busy_ignored_vec", 5, 32'h0040);
        #1; drain();

        // writeback clears busy
        wr(4'd6, 16'hBEEF);
        #1;
        want("wb6_pre_stall", 3, BYP ? 32'h0 : 32'h1);
        want("wb6_pre_rd", 0, BYP ? 32'hBEEF : 32'h0);
        drain();
        step(); idle();
        want("wb6_stall", 3, 32'h0);
        want("wb6_rd", 0, 32'hBEEF);
        want("wb6_vec", 5, 32'h0);
        #1; drain();

        // simultaneous set and clear on the same index: set wins
        wr(4'd2, 16'h0011); SetBusy = 1'b1; BusyReg = 4'd2;
        step(); idle();
        RdAddr[3:0] = 4'd2;
        want("simul_rd", 0, 32'h0011);
        want("simul_vec", 5, 32'h0004);
        want("simul_stall", 3, 32'h1);
        #1; drain();
        wr(4'd2, 16'h0022); SetBusy = 1'b1; BusyReg = 4'd2;
        want("simul_byp_rdbusy", 2, 32'h1);
        want("simul_byp_rd", 0, BYP ? 32'h0022 : 32'h0011);
        #1; drain();
        step(); idle();
        want("simul2_rd", 0, 32'h0022);
        want("simul2_vec", 5, 32'h0004);
        #1; drain();

        // peek sees post-write value and the PC alias
        wr(4'd7, 16'h0077); PeekSel = 4'd7;
        step(); idle();
        want("peek_r7", 4, 32'h0077); drain();
        PeekSel = 4'd15; PcAddr0 = 16'h0123;
        step();
        want("peek_pc", 4, 32'h0123); drain();

        // read-during-write
        wr(4'd4, 16'h1111);
        step(); idle();
        wr(4'd4, 16'hA5A5); RdAddr[7:4] = 4'd4;
        #1; want("rdw_pre", 1, BYP ? 32'hA5A5 : 32'h1111); drain();
        step(); idle();
        want("rdw_post", 1, 32'hA5A5); drain();
        wr(4'd0, 16'hFFFF); RdAddr[3:0] = 4'd0;
        #1; want("rdw_zero", 0, 32'h0); drain();
        step(); idle();

        // wide configuration
        w_wre = 1'b1; w_wreg = 5'd17; w_wdata = 32'hDEADBEEF;
        step(); idle();
        w_rd_addr = {5'd17, 5'd17, 5'd17};
        want("wide_rd0", 6, 32'hDEADBEEF);
        want("wide_rd1", 7, 32'hDEADBEEF);
        want("wide_rd2", 8, 32'hDEADBEEF);
        #1; drain();
        w_set = 1'b1; w_breg = 5'd31;
        step(); idle();
        want("wide_busy31", 9, 32'h8000_0000); drain();

        // reset in the middle of activity
        wr(4'd3, 16'h1234); SetBusy = 1'b1; BusyReg = 4'd5;
        step(); idle();
        RdAddr[3:0] = 4'd3;
        want("prerst_rd", 0, 32'h1234);
        want("prerst_vec", 5, 32'h0024);
        #1; drain();
        wr(4'd9, 16'h9999); SetBusy = 1'b1; BusyReg = 4'd8; PeekSel = 4'd3;
        @(posedge Clk);
        Rst = 1'b0;
        #1;
        want("midrst_rd", 0, 32'h0);
        want("midrst_vec", 5, 32'h0);
        want("midrst_peek", 4, 32'h0);
        drain();
        step();
        want("inrst_rd", 0, 32'h0);
        want("inrst_vec", 5, 32'h0);
        want("inrst_peek", 4, 32'h0);
        want("inrst_wide_vec", 9, 32'h0);
        drain();
        @(posedge Clk);
        Rst = 1'b1;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
